// File: rtl/axi_lite_arbiter_pkg.sv
// Shared definitions for the two-master AXI4-Lite arbiter: FSM state
// encoding and AXI response codes.
package axi_lite_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_M0_RD = 2'd1,
    ST_M1_RD = 2'd2,
    ST_M1_WR = 2'd3
  } arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite bundle (AR/R/AW/W/B). The master modport drives requests and
// the slave modport answers them.
interface axi_lite_arbiter_if
  import axi_lite_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_arbiter.sv
// Fixed-priority arbiter: LSU (m1, read+write) over IFU (m0, read-only) onto
// one AXI4-Lite slave, one transaction in flight, one idle cycle between grants.
module axi_lite_arbiter
  import axi_lite_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
)(
  input  logic              clock,
  input  logic              reset,
  axi_lite_arbiter_if.slave  m0,
  axi_lite_arbiter_if.slave  m1,
  axi_lite_arbiter_if.master s
);

  arb_state_t r_state;
  arb_state_t w_next_state;
  logic       r_addr_done;
  logic       r_w_done;
  logic       w_addr_hs;
  logic       w_w_hs;
  logic       w_unused;

  // The IFU never writes; its write channel inputs are intentionally ignored.
  assign w_unused = &{1'b0, m0.awaddr, m0.awvalid, m0.wdata, m0.wstrb, m0.wvalid, m0.bready};

  assign w_addr_hs = (s.arvalid && s.arready) || (s.awvalid && s.awready);
  assign w_w_hs    = s.wvalid && s.wready;

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Once an address/data beat is accepted, stop forwarding that valid so a
  // master still holding it cannot push a second beat into this grant.
  always_ff @(posedge clock) begin
    if (reset || r_state == ST_IDLE) begin
      r_addr_done <= 1'b0;
      r_w_done    <= 1'b0;
    end else begin
      if (w_addr_hs) r_addr_done <= 1'b1;
      if (w_w_hs)    r_w_done    <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (m1.awvalid)      w_next_state = ST_M1_WR;
        else if (m1.arvalid) w_next_state = ST_M1_RD;
        else if (m0.arvalid) w_next_state = ST_M0_RD;
      end
      ST_M0_RD: if (s.rvalid && m0.rready) w_next_state = ST_IDLE;
      ST_M1_RD: if (s.rvalid && m1.rready) w_next_state = ST_IDLE;
      ST_M1_WR: if (s.bvalid && m1.bready) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    m0.arready = 1'b0;
    m0.rdata   = {DATA_W{1'b0}};
    m0.rresp   = 2'b00;
    m0.rvalid  = 1'b0;
    m0.awready = 1'b0;
    m0.wready  = 1'b0;
    m0.bresp   = 2'b00;
    m0.bvalid  = 1'b0;
    m1.arready = 1'b0;
    m1.rdata   = {DATA_W{1'b0}};
    m1.rresp   = 2'b00;
    m1.rvalid  = 1'b0;
    m1.awready = 1'b0;
    m1.wready  = 1'b0;
    m1.bresp   = 2'b00;
    m1.bvalid  = 1'b0;
    s.araddr   = {ADDR_W{1'b0}};
    s.arvalid  = 1'b0;
    s.rready   = 1'b0;
    s.awaddr   = {ADDR_W{1'b0}};
    s.awvalid  = 1'b0;
    s.wdata    = {DATA_W{1'b0}};
    s.wstrb    = {(DATA_W/8){1'b0}};
    s.wvalid   = 1'b0;
    s.bready   = 1'b0;
    unique case (r_state)
      ST_M0_RD: begin
        s.araddr   = m0.araddr;
        s.arvalid  = m0.arvalid && !r_addr_done;
        m0.arready = s.arready && !r_addr_done;
        m0.rdata   = s.rdata;
        m0.rresp   = s.rresp;
        m0.rvalid  = s.rvalid;
        s.rready   = m0.rready;
      end
      ST_M1_RD: begin
        s.araddr   = m1.araddr;
        s.arvalid  = m1.arvalid && !r_addr_done;
        m1.arready = s.arready && !r_addr_done;
        m1.rdata   = s.rdata;
        m1.rresp   = s.rresp;
        m1.rvalid  = s.rvalid;
        s.rready   = m1.rready;
      end
      ST_M1_WR: begin
        s.awaddr   = m1.awaddr;
        s.awvalid  = m1.awvalid && !r_addr_done;
        m1.awready = s.awready && !r_addr_done;
        s.wdata    = m1.wdata;
        s.wstrb    = m1.wstrb;
        s.wvalid   = m1.wvalid && !r_w_done;
        m1.wready  = s.wready && !r_w_done;
        m1.bresp   = s.bresp;
        m1.bvalid  = s.bvalid;
        s.bready   = m1.bready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: stimulus pushes expected beats into
// queues, a negedge monitor pops and compares them as handshakes occur.
module tb_axi_lite_arbiter;
  import axi_lite_arbiter_pkg::*;

  localparam int LIM = 200;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  axi_lite_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  axi_lite_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
  axi_lite_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

  axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock (clock),
    .reset (reset),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if)
  );

  // Expected beats: addresses, {data,strb}, {data,resp}, resp, grant gaps.
  logic [31:0] q_s_ar[$];
  logic [31:0] q_s_aw[$];
  logic [35:0] q_s_w[$];
  logic [33:0] q_m0_r[$];
  logic [33:0] q_m1_r[$];
  logic [1:0]  q_m1_b[$];
  int          q_gap[$];

  // Written by the stimulus process only.
  int exp_owner  = 2;   // 0: IFU, 1: LSU, 2: nobody
  int n_timeouts = 0;
  bit tb_done    = 1'b0;

  // Written by the monitor process only.
  int n_checks   = 0;
  int n_errors   = 0;
  bit final_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic any_out();
    return |{m0_if.arready, m0_if.rdata, m0_if.rresp, m0_if.rvalid,
             m0_if.awready, m0_if.wready, m0_if.bresp, m0_if.bvalid,
             m1_if.arready, m1_if.rdata, m1_if.rresp, m1_if.rvalid,
             m1_if.awready, m1_if.wready, m1_if.bresp, m1_if.bvalid,
             s_if.araddr, s_if.arvalid, s_if.rready, s_if.awaddr, s_if.awvalid,
             s_if.wdata, s_if.wstrb, s_if.wvalid, s_if.bready};
  endfunction

  initial begin : monitor
    int  cyc = 0;
    int  done_cyc = 0;
    int  exp_gap = 0;
    bit  gap_armed = 1'b0;
    bit  idle_due = 1'b0;
    bit  prev_reset = 1'b1;
    bit  prev_req = 1'b0;
    bit  req_now;
    logic [33:0] er;
    logic [35:0] ew;
    forever begin
      @(negedge clock);
      cyc++;
      if (prev_reset || idle_due) chk("idle_outputs_zero", any_out(), 0);
      idle_due = 1'b0;
      if (exp_owner != 0) chk("m0_blocked", {m0_if.arready, m0_if.rvalid}, 0);
      if (exp_owner != 1)
        chk("m1_blocked", {m1_if.arready, m1_if.rvalid, m1_if.awready, m1_if.wready, m1_if.bvalid}, 0);

      if (s_if.arvalid && s_if.arready) begin
        if (q_s_ar.size() == 0) chk("s_ar_unexpected", 1, 0);
        else chk("s_araddr", s_if.araddr, q_s_ar.pop_front());
      end
      if (s_if.awvalid && s_if.awready) begin
        if (q_s_aw.size() == 0) chk("s_aw_unexpected", 1, 0);
        else chk("s_awaddr", s_if.awaddr, q_s_aw.pop_front());
      end
      if (s_if.wvalid && s_if.wready) begin
        if (q_s_w.size() == 0) chk("s_w_unexpected", 1, 0);
        else begin
          ew = q_s_w.pop_front();
          chk("s_wdata", s_if.wdata, ew[35:4]);
          chk("s_wstrb", s_if.wstrb, ew[3:0]);
        end
      end

      req_now = s_if.arvalid | s_if.awvalid | s_if.wvalid;
      if (req_now && !prev_req && gap_armed) begin
        chk("grant_gap", cyc - done_cyc, exp_gap);
        gap_armed = 1'b0;
      end
      prev_req = req_now;

      if ((m0_if.rvalid && m0_if.rready) || (m1_if.rvalid && m1_if.rready) ||
          (m1_if.bvalid && m1_if.bready)) begin
        idle_due = 1'b1;
        done_cyc = cyc;
        if (q_gap.size() > 0) begin
          exp_gap   = q_gap.pop_front();
          gap_armed = 1'b1;
        end
      end
      if (m0_if.rvalid && m0_if.rready) begin
        if (q_m0_r.size() == 0) chk("m0_r_unexpected", 1, 0);
        else begin
          er = q_m0_r.pop_front();
          chk("m0_rdata", m0_if.rdata, er[33:2]);
          chk("m0_rresp", m0_if.rresp, er[1:0]);
        end
      end
      if (m1_if.rvalid && m1_if.rready) begin
        if (q_m1_r.size() == 0) chk("m1_r_unexpected", 1, 0);
        else begin
          er = q_m1_r.pop_front();
          chk("m1_rdata", m1_if.rdata, er[33:2]);
          chk("m1_rresp", m1_if.rresp, er[1:0]);
        end
      end
      if (m1_if.bvalid && m1_if.bready) begin
        if (q_m1_b.size() == 0) chk("m1_b_unexpected", 1, 0);
        else chk("m1_bresp", m1_if.bresp, q_m1_b.pop_front());
      end
      prev_reset = reset;

      if (tb_done && !final_done) begin
        chk("queues_drained", q_s_ar.size() + q_s_aw.size() + q_s_w.size() +
            q_m0_r.size() + q_m1_r.size() + q_m1_b.size(), 0);
        chk("gap_pending", q_gap.size() + int'(gap_armed), 0);
        chk("wait_timeouts", n_timeouts, 0);
        final_done = 1'b1;
      end
    end
  end

  function automatic logic sig(input int which);
    case (which)
      0:  return m0_if.arready;
      1:  return m0_if.rvalid;
      2:  return m1_if.arready;
      3:  return m1_if.rvalid;
      4:  return m1_if.awready;
      5:  return m1_if.wready;
      6:  return m1_if.bvalid;
      7:  return s_if.arvalid;
      8:  return s_if.rready;
      9:  return s_if.awvalid;
      10: return s_if.wvalid;
      11: return s_if.bready;
      default: return 1'b0;
    endcase
  endfunction

  // Returns at posedge+1 after the edge on which the signal was high.
  task automatic wait_hs(input int which);
    int n = 0;
    @(negedge clock);
    while (!sig(which) && n < LIM) begin
      @(negedge clock);
      n++;
    end
    if (!sig(which)) begin
      n_timeouts++;
      $display("FAIL wait_sig_%0d: got 0, expected 1 within %0d cycles", which, LIM);
    end
    @(posedge clock); #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic m0_read(input logic [31:0] a);
    m0_if.araddr = a; m0_if.arvalid = 1'b1;
    wait_hs(0);
    m0_if.arvalid = 1'b0; m0_if.araddr = '0; m0_if.rready = 1'b1;
    wait_hs(1);
    m0_if.rready = 1'b0;
  endtask

  task automatic m1_read(input logic [31:0] a);
    m1_if.araddr = a; m1_if.arvalid = 1'b1;
    wait_hs(2);
    m1_if.arvalid = 1'b0; m1_if.araddr = '0; m1_if.rready = 1'b1;
    wait_hs(3);
    m1_if.rready = 1'b0;
  endtask

  task automatic m1_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] strb);
    m1_if.awaddr = a; m1_if.awvalid = 1'b1;
    m1_if.wdata = d; m1_if.wstrb = strb; m1_if.wvalid = 1'b1;
    fork
      begin wait_hs(4); m1_if.awvalid = 1'b0; m1_if.awaddr = '0; end
      begin wait_hs(5); m1_if.wvalid = 1'b0; m1_if.wdata = '0; m1_if.wstrb = '0; end
    join
    m1_if.bready = 1'b1;
    wait_hs(6);
    m1_if.bready = 1'b0;
  endtask

  task automatic s_read(input int ar_d, input int r_d, input logic [31:0] d, input logic [1:0] resp);
    wait_hs(7);
    cycles(ar_d);
    s_if.arready = 1'b1;
    wait_hs(7);
    s_if.arready = 1'b0;
    cycles(r_d);
    s_if.rvalid = 1'b1; s_if.rdata = d; s_if.rresp = resp;
    wait_hs(8);
    s_if.rvalid = 1'b0; s_if.rdata = '0; s_if.rresp = '0;
  endtask

  task automatic s_write(input bit w_first, input logic [1:0] resp);
    wait_hs(9);
    cycles(1);
    if (w_first) begin
      s_if.wready = 1'b1;  wait_hs(10); s_if.wready = 1'b0;
      cycles(1);
      s_if.awready = 1'b1; wait_hs(9);  s_if.awready = 1'b0;
    end else begin
      s_if.awready = 1'b1; wait_hs(9);  s_if.awready = 1'b0;
      cycles(1);
      s_if.wready = 1'b1;  wait_hs(10); s_if.wready = 1'b0;
    end
    cycles(1);
    s_if.bvalid = 1'b1; s_if.bresp = resp;
    wait_hs(11);
    s_if.bvalid = 1'b0; s_if.bresp = '0;
  endtask

  initial begin : stimulus
    m0_if.araddr = '0; m0_if.arvalid = 1'b0; m0_if.rready = 1'b0;
    m0_if.awaddr = '0; m0_if.awvalid = 1'b0; m0_if.wdata = '0;
    m0_if.wstrb = '0;  m0_if.wvalid = 1'b0;  m0_if.bready = 1'b0;
    m1_if.araddr = '0; m1_if.arvalid = 1'b0; m1_if.rready = 1'b0;
    m1_if.awaddr = '0; m1_if.awvalid = 1'b0; m1_if.wdata = '0;
    m1_if.wstrb = '0;  m1_if.wvalid = 1'b0;  m1_if.bready = 1'b0;
    s_if.arready = 1'b0; s_if.rdata = '0; s_if.rresp = '0; s_if.rvalid = 1'b0;
    s_if.awready = 1'b0; s_if.wready = 1'b0; s_if.bresp = '0; s_if.bvalid = 1'b0;
    cycles(3);
    reset = 1'b0;

    // IFU fetch: arready 2 cycles after request, rvalid 3 cycles later
    exp_owner = 0;
    q_s_ar.push_back(32'h8000_0000);
    q_m0_r.push_back({32'h0000_0413, RESP_OKAY});
    fork
      m0_read(32'h8000_0000);
      s_read(2, 3, 32'h0000_0413, RESP_OKAY);
    join
    cycles(2);

    // LSU byte store, W accepted before AW, IFU waiting the whole time
    exp_owner = 1;
    q_s_aw.push_back(32'h8000_0102);
    q_s_w.push_back({32'h00AB_0000, 4'b0100});
    q_m1_b.push_back(RESP_OKAY);
    q_s_ar.push_back(32'h8000_0004);
    q_m0_r.push_back({32'h0000_0093, RESP_OKAY});
    q_gap.push_back(2);
    fork
      begin m1_write(32'h8000_0102, 32'h00AB_0000, 4'b0100); exp_owner = 0; end
      m0_read(32'h8000_0004);
      begin s_write(1'b1, RESP_OKAY); s_read(1, 1, 32'h0000_0093, RESP_OKAY); end
    join
    cycles(2);

    // simultaneous reads: LSU first, IFU after one idle cycle
    exp_owner = 1;
    q_s_ar.push_back(32'h8000_1000);
    q_m1_r.push_back({32'h1111_2222, RESP_OKAY});
    q_s_ar.push_back(32'h8000_0008);
    q_m0_r.push_back({32'h0000_0513, RESP_OKAY});
    q_gap.push_back(2);
    fork
      begin m1_read(32'h8000_1000); exp_owner = 0; end
      m0_read(32'h8000_0008);
      begin s_read(1, 1, 32'h1111_2222, RESP_OKAY); s_read(1, 2, 32'h0000_0513, RESP_OKAY); end
    join
    cycles(2);

    // DECERR read passes through, then a normal IFU read
    exp_owner = 1;
    q_s_ar.push_back(32'hA000_03F8);
    q_m1_r.push_back({32'hDEAD_BEEF, RESP_DECERR});
    fork
      m1_read(32'hA000_03F8);
      s_read(1, 1, 32'hDEAD_BEEF, RESP_DECERR);
    join
    cycles(1);
    exp_owner = 0;
    q_s_ar.push_back(32'h8000_000C);
    q_m0_r.push_back({32'h0000_0613, RESP_OKAY});
    fork
      m0_read(32'h8000_000C);
      s_read(1, 1, 32'h0000_0613, RESP_OKAY);
    join
    cycles(2);

    // reset after AW accepted, before W/B; stray slave responses in IDLE
    exp_owner = 1;
    q_s_aw.push_back(32'h8000_0200);
    m1_if.awaddr = 32'h8000_0200; m1_if.awvalid = 1'b1;
    m1_if.wdata = 32'h5555_AAAA;  m1_if.wstrb = 4'hF; m1_if.wvalid = 1'b1;
    wait_hs(9);
    s_if.awready = 1'b1;
    wait_hs(4);
    s_if.awready = 1'b0; m1_if.awvalid = 1'b0; m1_if.bready = 1'b1;
    cycles(1);
    reset = 1'b1;
    cycles(1);
    exp_owner = 2;
    s_if.bvalid = 1'b1; s_if.bresp = RESP_SLVERR; s_if.rvalid = 1'b1; s_if.rdata = 32'h0BAD_0BAD;
    cycles(1);
    reset = 1'b0;
    m1_if.wvalid = 1'b0; m1_if.bready = 1'b0; m1_if.awaddr = '0; m1_if.wdata = '0; m1_if.wstrb = '0;
    s_if.bvalid = 1'b0; s_if.bresp = '0; s_if.rvalid = 1'b0; s_if.rdata = '0;
    cycles(1);
    exp_owner = 0;
    q_s_ar.push_back(32'h8000_0010);
    q_m0_r.push_back({32'h0000_0713, RESP_OKAY});
    fork
      m0_read(32'h8000_0010);
      s_read(1, 1, 32'h0000_0713, RESP_OKAY);
    join
    cycles(2);

    // LSU load with the following store already held: two grants, one bubble
    exp_owner = 1;
    q_s_ar.push_back(32'h8000_2000);
    q_m1_r.push_back({32'h0102_0304, RESP_OKAY});
    q_s_aw.push_back(32'h8000_2004);
    q_s_w.push_back({32'hCAFE_F00D, 4'b1111});
    q_m1_b.push_back(RESP_SLVERR);
    q_gap.push_back(2);
    fork
      m1_read(32'h8000_2000);
      begin cycles(3); m1_write(32'h8000_2004, 32'hCAFE_F00D, 4'b1111); end
      begin s_read(1, 2, 32'h0102_0304, RESP_OKAY); s_write(1'b0, RESP_SLVERR); end
    join
    cycles(2);
    exp_owner = 2;

    tb_done = 1'b1;
    repeat (3) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
